// File: rtl/dmem_arbiter.sv
// Two-port (CPU + loader) arbiter in front of a single-ported, asynchronously read DRAM.
// Round-robin selection, one access per cycle; partial CPU writes take a read-modify-write second cycle.
module dmem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state_reg, state_next;
    logic        ptr_reg;          // 0 favours CPU, 1 favours loader
    logic [31:0] merge_reg;
    logic [31:0] cpu_rdata_reg, ld_rdata_reg;
    logic        cpu_rvalid_reg, ld_rvalid_reg;

    logic        sel_cpu, sel_ld;
    logic        merge_load, cpu_read, ld_read;
    logic [31:0] merged_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[1:0], ld_addr[1:0]};

    assign sel_cpu = cpu_req && (!ld_req || !ptr_reg);
    assign sel_ld  = ld_req && !sel_cpu;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_data[gi*8 +: 8] = cpu_be[gi] ? cpu_wdata[gi*8 +: 8]
                                                       : merge_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cpu_gnt        = 1'b0;
        ld_gnt         = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;
        merge_load     = 1'b0;
        cpu_read       = 1'b0;
        ld_read        = 1'b0;
        // Everything is gated by rst so an in-flight RMW never emits its write.
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (sel_cpu) begin
                        mem_addr = {cpu_addr[31:2], 2'b00};
                        if (!cpu_we) begin
                            cpu_gnt  = 1'b1;
                            cpu_read = 1'b1;
                        end else if (cpu_be == 4'b1111) begin
                            mem_we         = 1'b1;
                            mem_write_data = cpu_wdata;
                            cpu_gnt        = 1'b1;
                        end else if (cpu_be == 4'b0000) begin
                            cpu_gnt = 1'b1;
                        end else begin
                            merge_load = 1'b1;
                            state_next = RMW_WR;
                        end
                    end else if (sel_ld) begin
                        mem_addr = {ld_addr[31:2], 2'b00};
                        ld_gnt   = 1'b1;
                        if (ld_we) begin
                            mem_we         = 1'b1;
                            mem_write_data = ld_wdata;
                        end else begin
                            ld_read = 1'b1;
                        end
                    end
                end
                RMW_WR: begin
                    mem_addr       = {cpu_addr[31:2], 2'b00};
                    mem_we         = 1'b1;
                    mem_write_data = merged_data;
                    cpu_gnt        = 1'b1;
                    state_next     = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b0;
            merge_reg      <= 32'h0;
            cpu_rdata_reg  <= 32'h0;
            ld_rdata_reg   <= 32'h0;
            cpu_rvalid_reg <= 1'b0;
            ld_rvalid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cpu_gnt)
                ptr_reg <= 1'b1;
            else if (ld_gnt)
                ptr_reg <= 1'b0;
            if (merge_load)
                merge_reg <= mem_read_data;
            cpu_rvalid_reg <= cpu_read;
            ld_rvalid_reg  <= ld_read;
            if (cpu_read)
                cpu_rdata_reg <= mem_read_data;
            if (ld_read)
                ld_rdata_reg <= mem_read_data;
        end
    end

    assign cpu_rvalid = cpu_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign ld_rvalid  = ld_rvalid_reg;
    assign ld_rdata   = ld_rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset: clk and rst.
REQ-002 It SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU port access request; held until cpu_gnt.
- cpu_we  in  1  CPU write (1) or read (0).
- cpu_be  in  4  CPU byte enables for writes; bit i maps to byte i; ignored on reads.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data, byte-lane aligned.
- cpu_gnt  out  1  CPU access completes this cycle.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  32  CPU read word.
- ld_req  in  1  loader port request; word-only; held until ld_gnt.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write word.
- ld_gnt  out  1  loader access completes this cycle.
- ld_rvalid  out  1  ld_rdata valid.
- ld_rdata  out  32  loader read word.
- mem_we  out  1  DRAM write enable.
- mem_addr  out  32  DRAM byte address; DRAM uses bits [15:2].
- mem_write_data  out  32  DRAM write data.
- mem_read_data  in  32  DRAM combinational (asynchronous) read data.

Function
REQ-003 Request inputs SHALL be sampled only while cpu_req/ld_req is high; a requester SHALL keep req and all request fields stable until its gnt is seen.
REQ-004 States SHALL be IDLE and RMW_WR.
REQ-005 In IDLE, if exactly one req is high, that requester SHALL be selected; if both are high, the requester named by the round-robin pointer SHALL be selected.
REQ-006 After any gnt, the pointer SHALL move to the other requester; at reset, the pointer favours the CPU.
REQ-007 mem_addr SHALL be {addr[31:2],2'b00} of the selected requester; with no selection, mem_addr = 0, mem_we = 0 and mem_write_data = 0.
REQ-008 A read (either port) SHALL be issued in one cycle:
- gnt is high in the issue cycle;
- mem_read_data is registered into the port's rdata at that edge;
- the port's rvalid is high for exactly one cycle, the cycle after gnt.
REQ-009 A loader write, or a CPU write with cpu_be = 4'b1111, SHALL complete in one cycle:
- mem_we = 1 and mem_write_data = wdata in that cycle;
- gnt is high in that cycle;
- no rvalid is produced.
REQ-010 A CPU write with cpu_be = 4'b0000 SHALL complete in one cycle as a no-op: cpu_gnt = 1 and mem_we = 0.
REQ-011 A CPU write with a partial cpu_be (not all-ones and not zero) SHALL use read-modify-write:
- cycle 1 (IDLE): mem_we = 0, cpu_gnt = 0; mem_read_data is latched into a merge register; state becomes RMW_WR;
- cycle 2 (RMW_WR): mem_addr held, mem_we = 1, mem_write_data per lane = cpu_be[i] ? cpu_wdata byte i : latched byte i; cpu_gnt = 1; state returns to IDLE.
REQ-012 During RMW_WR, ld_gnt SHALL be 0 regardless of ld_req; the loader is served no earlier than the following cycle.
REQ-013 At most one gnt SHALL be high in any cycle, and there SHALL be at most one DRAM access per cycle.
REQ-014 cpu_rdata and ld_rdata SHALL hold their last value until the next read on that port.
REQ-015 Back-to-back requests SHALL be accepted in consecutive cycles, with no idle bubble except the RMW second cycle.

Reset
REQ-016 With rst high at a clock edge, the next state SHALL be:
- state = IDLE, pointer = CPU;
- cpu_gnt = ld_gnt = cpu_rvalid = ld_rvalid = 0;
- cpu_rdata = ld_rdata = 0, merge register = 0.
REQ-017 While rst is high, mem_we SHALL be 0 and no gnt SHALL be asserted.
REQ-018 Reset asserted in RMW_WR SHALL abort the write: no mem_we pulse and no cpu_gnt.

Verification
REQ-019 CPU read of addr 0x0000_0010, DRAM word 0xDEADBEEF -> cpu_gnt in cycle 0; cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF in cycle 1; mem_we never high.
REQ-020 CPU write be = 4'b0010, wdata = 0x0000AB00, to word 0x11223344 -> cycle 0 mem_we = 0; cycle 1 mem_we = 1, mem_write_data = 0x1122AB44, cpu_gnt = 1.
REQ-021 cpu_req and ld_req held high continuously from reset, all reads -> gnts alternate CPU, LD, CPU, LD, one per cycle.
REQ-022 ld_req raised during a partial CPU write -> ld_gnt low in RMW_WR; ld_gnt high the next cycle (the pointer then favours the loader).
REQ-023 rst asserted in RMW_WR -> no mem_we pulse, no cpu_gnt; all outputs at reset values the next cycle.
REQ-024 CPU write with be = 4'b0000 -> cpu_gnt = 1 in one cycle, mem_we = 0, DRAM contents unchanged.
